banco_regs_param: RTL
=====================

# banco_regs_param

Parametrised, clocked successor to the team's 32x32 register bank: a multi-entry register file with two combinational read ports, one synchronous write port, optional hard-wired zero entry, optional write-to-read bypass, and an on-demand sequential clear engine. It sits between decode (read addresses) and writeback (write port) in the datapath and replaces the level-sensitive bank.

## Interface
Parameters:
- DATA_W, 32, width of each entry and of all data ports
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data (combinational)
- rd_data2  out  DATA_W  read port 2 data (combinational)
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  start a full clear (single-cycle pulse or level; sampled only in IDLE)
- busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse when the clear completes

## Operation
- Reset (rst_n=0, asynchronous): all DEPTH entries = 0, state IDLE, clear pointer = 0, busy = 0, clr_done = 0. rd_data follow the zeroed array immediately.
- Write: on the rising edge with we=1, busy=0, and not (ZERO_REG and wr_addr==0), entry[wr_addr] <= wr_data.
- Read: rd_dataN = entry[rd_addrN]; forced to 0 when ZERO_REG and rd_addrN==0.
- Bypass (BYPASS=1): if we=1, busy=0, wr_addr==rd_addrN, and the write is not discarded, rd_dataN = wr_data in the same cycle. Both ports may be bypassed at once. With BYPASS=0, reads return the old value until the edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 at an edge -> CLEAR, pointer <= 0. A write in that same edge still commits and is then erased by the clear.
  - CLEAR: each edge sets entry[pointer] <= 0 and increments pointer. The edge that writes entry DEPTH-1 -> IDLE and asserts clr_done for the following cycle.
  - busy = (state==CLEAR).
- While busy: we is ignored (the write is dropped, not queued), bypass is disabled, clr_req is ignored, and reads return current array contents (a mix of cleared and uncleared entries).
- Pointer is ADDR_W bits and wraps to 0 naturally after DEPTH-1; it is never used in IDLE.

## Timing
- Read latency: 0 cycles (combinational from address and array).
- Write latency: 1 edge; visible on the read ports from the cycle after the edge, or in the same cycle via bypass.
- Clear: clr_req sampled at edge T0; busy=1 during cycles T0+1 .. T0+DEPTH; clr_done=1 during cycle T0+DEPTH+1 only, with busy=0 in that cycle; the first write is accepted at edge T0+DEPTH+1.
- rst_n asserted mid-clear: immediate return to the reset state; no clr_done pulse.
- rst_n deasserted: the first edge may carry a write or a clr_req.

## Structure
- Shared package banco_pkg: state typedef (IDLE, CLEAR) and default DATA_W/ADDR_W constants.
- One natural sub-module, banco_clr_fsm: state, pointer, busy, clr_done, and the clear write strobe/address. The top module holds the array, the write mux (port write vs clear write), the zero-register logic and the bypass logic.

## Test plan
- Reset, then write 0xDEADBEEF to entry 5; read addr1=5 on the next cycle -> 0xDEADBEEF; addr2=6 -> 0.
- ZERO_REG=1: write 0x12345678 to entry 0 -> rd_data1 at addr 0 stays 0 before and after the edge.
- BYPASS=1: we=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr1=rd_addr2=7 -> both ports show 0xA5A5A5A5 in the same cycle. With BYPASS=0 -> both show the old value, then the new value after the edge.
- Fill entries 1..31 with their index; pulse clr_req -> busy high for exactly 32 cycles, clr_done pulses once, all entries read 0. A write issued while busy (entry 3 = 0x55) is absent afterwards.
- clr_req and a write (entry 9 = 0x99) on the same edge -> entry 9 reads 0 after clr_done.
- Assert rst_n low at clear cycle 10 of 32 -> busy=0 immediately, all entries 0, no clr_done pulse; a normal write works after release.

Source files
------------

// File: rtl/banco_pkg.sv
// Shared types and default widths for the parametrised register bank.
package banco_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } banco_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/banco_regs_if.sv
// Port bundle of the register bank: decode-side reads, writeback-side write, clear control.
interface banco_regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // No valid/ready pair: reads are combinational every cycle. A write is taken
    // on any edge with we=1 and busy=0. clr_req is honoured only while busy=0,
    // and clr_done pulses for one cycle once the last entry has been cleared.
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              busy;
    logic              clr_done;

    modport master (
        output rd_addr1, rd_addr2, we, wr_addr, wr_data, clr_req,
        input  rd_data1, rd_data2, busy, clr_done
    );

    modport slave (
        input  rd_addr1, rd_addr2, we, wr_addr, wr_data, clr_req,
        output rd_data1, rd_data2, busy, clr_done
    );

endinterface

// File: rtl/banco_clr_fsm.sv
// Sequential clear engine: walks a pointer over every entry, one per edge,
// and pulses clr_done in the cycle after the last entry is zeroed.
module banco_clr_fsm
    import banco_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output banco_state_e      state
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    banco_state_e      state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic              done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            clr_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        done_n  = 1'b0;
        clr_we  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_n = CLEAR;
                    ptr_n   = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                ptr_n  = ptr + 1'b1;
                // The edge that zeroes the last entry also closes the clear.
                if (ptr == LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/banco_regs_param.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, optional zero entry, optional write bypass, on-demand clear.
module banco_regs_param
    import banco_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    banco_regs_if.slave  bus,
    output banco_state_e dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy, clr_done, clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic [DATA_W-1:0] rd1, rd2;

    banco_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .state    (dbg_state)
    );

    // Port writes are dropped while clearing and when they target the zero entry.
    assign wr_ok = bus.we && !busy && !(ZERO_REG && (bus.wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd1 = mem[bus.rd_addr1];
        rd2 = mem[bus.rd_addr2];
        if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr1)) rd1 = bus.wr_data;
        if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr2)) rd2 = bus.wr_data;
        if (ZERO_REG && (bus.rd_addr1 == '0)) rd1 = '0;
        if (ZERO_REG && (bus.rd_addr2 == '0)) rd2 = '0;
    end

    assign bus.rd_data1 = rd1;
    assign bus.rd_data2 = rd2;
    assign bus.busy     = busy;
    assign bus.clr_done = clr_done;

endmodule
